// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: PC register controls, redirect sources and perf counters.
interface fetch_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [31:0]       FC_CUR_PC;
    logic              FC_IMISS;
    logic              FC_IRDY;
    logic              FC_HAZ_STALL;
    logic              FC_BR_TAKEN;
    logic [31:0]       FC_BR_TGT;
    logic              FC_TRAP;
    logic [31:0]       FC_TRAP_TGT;
    logic              FC_PC_LD;
    logic [31:0]       FC_PC_DIN;
    logic              FC_PC_STALL;
    logic              FC_IF_FLUSH;
    logic              FC_ID_FLUSH;
    logic              FC_MISS_ERR;
    logic [PERF_W-1:0] FC_STALL_CNT;
    logic [PERF_W-1:0] FC_MISS_CNT;

    modport master (
        input  FC_CUR_PC, FC_IMISS, FC_IRDY, FC_HAZ_STALL,
        input  FC_BR_TAKEN, FC_BR_TGT, FC_TRAP, FC_TRAP_TGT,
        output FC_PC_LD, FC_PC_DIN, FC_PC_STALL,
        output FC_IF_FLUSH, FC_ID_FLUSH, FC_MISS_ERR,
        output FC_STALL_CNT, FC_MISS_CNT
    );

    modport slave (
        output FC_CUR_PC, FC_IMISS, FC_IRDY, FC_HAZ_STALL,
        output FC_BR_TAKEN, FC_BR_TGT, FC_TRAP, FC_TRAP_TGT,
        input  FC_PC_LD, FC_PC_DIN, FC_PC_STALL,
        input  FC_IF_FLUSH, FC_ID_FLUSH, FC_MISS_ERR,
        input  FC_STALL_CNT, FC_MISS_CNT
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: redirect arbitration, icache-miss hold with
// buffered redirect, miss timeout flag and saturating perf counters.
module fetch_ctrl #(
    parameter int PERF_W       = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input logic          FC_CLK,
    input logic          FC_RST,
    fetch_ctrl_if.master bus
);
    localparam int TW = $clog2(MISS_TIMEOUT + 1);

    typedef enum logic {RUN, MISS} state_e;

    state_e            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_trap_q, pend_trap_d;
    logic [31:0]       pend_tgt_q, pend_tgt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [PERF_W-1:0] stall_cnt_q, miss_cnt_q;

    logic        pc_ld, pc_stall, if_flush, id_flush, miss_ent;
    logic [31:0] pc_din;

    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_trap_d = pend_trap_q;
        pend_tgt_d  = pend_tgt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        pc_ld       = 1'b1;
        pc_stall    = 1'b0;
        pc_din      = bus.FC_CUR_PC + 32'd4;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        miss_ent    = 1'b0;
        if (FC_RST) begin
            pc_ld    = 1'b0;
            pc_stall = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            pc_din   = 32'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.FC_TRAP) begin
                        pc_din   = bus.FC_TRAP_TGT;
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                    end else if (bus.FC_BR_TAKEN) begin
                        pc_din   = bus.FC_BR_TGT;
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                    end else if (bus.FC_IMISS) begin
                        pc_din   = bus.FC_CUR_PC;
                        pc_stall = 1'b1;
                        if_flush = 1'b1;
                        miss_ent = 1'b1;
                        state_d  = MISS;
                    end else if (bus.FC_HAZ_STALL) begin
                        pc_din   = bus.FC_CUR_PC;
                        pc_stall = 1'b1;
                    end
                end
                MISS: begin
                    pc_din   = bus.FC_CUR_PC;
                    pc_stall = 1'b1;
                    if_flush = 1'b1;
                    id_flush = bus.FC_TRAP | bus.FC_BR_TAKEN;
                    if (tmo_q != TW'(MISS_TIMEOUT))
                        tmo_d = tmo_q + TW'(1);
                    if (tmo_q == TW'(MISS_TIMEOUT - 1))
                        err_d = 1'b1;
                    if (bus.FC_IRDY) begin
                        pc_stall   = 1'b0;
                        pend_vld_d = 1'b0;
                        tmo_d      = '0;
                        state_d    = RUN;
                        if (bus.FC_TRAP)
                            pc_din = bus.FC_TRAP_TGT;
                        else if (bus.FC_BR_TAKEN)
                            pc_din = bus.FC_BR_TGT;
                        else if (pend_vld_q)
                            pc_din = pend_tgt_q;
                    end else if (bus.FC_TRAP) begin
                        pend_vld_d  = 1'b1;
                        pend_trap_d = 1'b1;
                        pend_tgt_d  = bus.FC_TRAP_TGT;
                    end else if (bus.FC_BR_TAKEN &&
                                 !(pend_vld_q && pend_trap_q)) begin
                        // a buffered trap outranks any later branch
                        pend_vld_d  = 1'b1;
                        pend_trap_d = 1'b0;
                        pend_tgt_d  = bus.FC_BR_TGT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge FC_CLK) begin
        if (FC_RST) begin
            state_q     <= RUN;
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_trap_q <= pend_trap_d;
            pend_tgt_q  <= pend_tgt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            if (pc_stall && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (miss_ent && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + PERF_W'(1);
        end
    end

    assign bus.FC_PC_LD     = pc_ld;
    assign bus.FC_PC_DIN    = pc_din;
    assign bus.FC_PC_STALL  = pc_stall;
    assign bus.FC_IF_FLUSH  = if_flush;
    assign bus.FC_ID_FLUSH  = id_flush;
    assign bus.FC_MISS_ERR  = err_q;
    assign bus.FC_STALL_CNT = stall_cnt_q;
    assign bus.FC_MISS_CNT  = miss_cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a
// behavioural model of the fetch PC, pending redirect and counters.
module tb_fetch_ctrl;
    localparam int PW  = 6;
    localparam int TO  = 8;
    localparam int SAT = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.PERF_W(PW)) bus ();

    fetch_ctrl #(.PERF_W(PW), .MISS_TIMEOUT(TO)) dut (
        .FC_CLK (clk),
        .FC_RST (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc = 0;
    logic [31:0] m_ptgt = 0;
    bit          m_miss = 0, m_pv = 0, m_pt = 0, m_err = 0;
    int          m_mc = 0, m_sc = 0, m_mcnt = 0;
    logic [31:0] obs_din;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit im, input bit rd,
                        input bit hz, input bit br, input logic [31:0] bt,
                        input bit tr, input logic [31:0] tt);
        logic [31:0] e_din;
        bit e_ld, e_st, e_if, e_id;
        rst              = r;
        bus.FC_CUR_PC    = m_pc;
        bus.FC_IMISS     = im;
        bus.FC_IRDY      = rd;
        bus.FC_HAZ_STALL = hz;
        bus.FC_BR_TAKEN  = br;
        bus.FC_BR_TGT    = bt;
        bus.FC_TRAP      = tr;
        bus.FC_TRAP_TGT  = tt;
        @(negedge clk);
        e_din = m_pc; e_ld = 1; e_st = 0; e_if = 0; e_id = 0;
        if (r) begin
            e_ld = 0; e_st = 1; e_if = 1; e_id = 1; e_din = 0;
        end else if (!m_miss) begin
            if (tr) begin e_din = tt; e_if = 1; e_id = 1; end
            else if (br) begin e_din = bt; e_if = 1; e_id = 1; end
            else if (im) begin e_st = 1; e_if = 1; end
            else if (hz) e_st = 1;
            else e_din = m_pc + 32'd4;
        end else begin
            e_st = 1; e_if = 1; e_id = tr | br;
            if (rd) begin
                e_st = 0;
                e_din = tr ? tt : br ? bt : m_pv ? m_ptgt : m_pc;
            end
        end
        if (r || !m_miss) chk("pc_ld", 32'(bus.FC_PC_LD), 32'(e_ld));
        chk("pc_stall", 32'(bus.FC_PC_STALL), 32'(e_st));
        chk("if_flush", 32'(bus.FC_IF_FLUSH), 32'(e_if));
        chk("id_flush", 32'(bus.FC_ID_FLUSH), 32'(e_id));
        if (r || !e_st) chk("pc_din", bus.FC_PC_DIN, e_din);
        chk("miss_err", 32'(bus.FC_MISS_ERR), 32'(m_err));
        chk("stall_cnt", 32'(bus.FC_STALL_CNT), 32'(m_sc));
        chk("miss_cnt", 32'(bus.FC_MISS_CNT), 32'(m_mcnt));
        obs_din = bus.FC_PC_DIN;
        if (r) begin
            m_pc = 0; m_miss = 0; m_pv = 0; m_pt = 0; m_err = 0;
            m_mc = 0; m_sc = 0; m_mcnt = 0;
        end else begin
            if (e_st && m_sc < SAT) m_sc++;
            if (!m_miss) begin
                if (!e_st) m_pc = e_din;
                if (!tr && !br && im) begin
                    m_miss = 1; m_mc = 0;
                    if (m_mcnt < SAT) m_mcnt++;
                end
            end else begin
                m_mc++;
                if (m_mc >= TO) m_err = 1;
                if (rd) begin
                    m_miss = 0; m_pv = 0; m_mc = 0; m_pc = e_din;
                end else if (tr) begin
                    m_pv = 1; m_pt = 1; m_ptgt = tt;
                end else if (br && !(m_pv && m_pt)) begin
                    m_pv = 1; m_pt = 0; m_ptgt = bt;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst_cyc();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit tr, br;
        logic [31:0] tt, bt;
        @(posedge clk);
        #1;
        rst_cyc();
        rst_cyc();

        idle(); chk("idle0", obs_din, 32'h4);
        idle(); chk("idle1", obs_din, 32'h8);
        idle(); chk("idle2", obs_din, 32'hC);

        m_pc = 32'h100;
        step(0, 0, 0, 1, 1, 32'h200, 0, 0);
        chk("br_over_haz", obs_din, 32'h200);
        chk("br_no_stall", 32'(bus.FC_STALL_CNT), 32'd0);

        m_pc = 32'h40;
        repeat (5) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("refetch", obs_din, 32'h40);
        chk("miss_stall5", 32'(bus.FC_STALL_CNT), 32'd5);
        chk("miss_cnt1", 32'(bus.FC_MISS_CNT), 32'd1);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h300, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h1C0);
        step(0, 0, 0, 0, 1, 32'h500, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("pend_trap", obs_din, 32'h1C0);
        idle();
        chk("back_run", obs_din, 32'h1C4);

        m_pc = 32'hFFFF_FFFC;
        idle();
        chk("pc_wrap", obs_din, 32'h0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (9) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo_set", 32'(bus.FC_MISS_ERR), 32'd1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("tmo_sticky", 32'(bus.FC_MISS_ERR), 32'd1);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h300, 0, 0);
        rst_cyc();
        chk("rst_err_clr", 32'(bus.FC_MISS_ERR), 32'd0);
        m_pc = 32'h80;
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("rst_drop_pend", obs_din, 32'h84);

        for (int i = 0; i < 3000; i++) begin
            tr = ($urandom_range(15) == 0);
            br = ($urandom_range(7) == 0);
            tt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            bt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(31) == 0) m_pc = 32'hFFFF_FFFC;
            step($urandom_range(199) == 0,
                 $urandom_range(5) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(4) == 0,
                 br, bt, tr, tt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch-stage program counter register and drives its load, data and stall inputs every cycle.
- Arbitrates between sequential advance (PC+4), branch/jump redirect from EX and trap redirect from the CSR unit.
- Holds the PC while the instruction cache refills a miss, and while decode requests a load-use stall.
- Buffers a redirect that arrives mid-miss and applies it when the refill completes; keeps stall/miss performance counters.

Parameters:
- PERF_W, 32, width of the stall-cycle and miss-count counters (saturating).
- MISS_TIMEOUT, 1024, miss cycles after which FC_MISS_ERR is raised.

Ports:
- FC_CLK  in  1  clock; all state updates on rising edge.
- FC_RST  in  1  synchronous, active-high reset.
- FC_CUR_PC  in  32  current PC register value.
- FC_IMISS  in  1  icache miss on current fetch.
- FC_IRDY  in  1  icache refill complete, 1-cycle pulse.
- FC_HAZ_STALL  in  1  load-use stall request from decode.
- FC_BR_TAKEN  in  1  branch/jump taken, resolved in EX.
- FC_BR_TGT  in  32  branch/jump target.
- FC_TRAP  in  1  trap/mret redirect request.
- FC_TRAP_TGT  in  32  trap vector or mepc.
- FC_PC_LD  out  1  to PC register load enable.
- FC_PC_DIN  out  32  next PC value.
- FC_PC_STALL  out  1  to PC register stall (blocks the load).
- FC_IF_FLUSH  out  1  squash the IF/ID pipeline register.
- FC_ID_FLUSH  out  1  squash the ID/EX pipeline register.
- FC_MISS_ERR  out  1  sticky miss-timeout flag.
- FC_STALL_CNT  out  PERF_W  cycles with FC_PC_STALL=1.
- FC_MISS_CNT  out  PERF_W  number of RUN->MISS entries.

Behaviour:
- All PC-control outputs are combinational from state and inputs. The PC register samples them on the same edge, so redirect latency is 1 edge.
- During FC_RST=1:
  - PC_LD=0, PC_STALL=1, IF_FLUSH=1, ID_FLUSH=1, PC_DIN=0.
  - After the edge: state=RUN, pending cleared, timeout counter=0, MISS_ERR=0, both perf counters=0.
  - Reset mid-miss discards any pending redirect.
- States: RUN, MISS.
- RUN priority, highest first:
  1. FC_TRAP: PC_LD=1, PC_STALL=0, PC_DIN=TRAP_TGT, IF_FLUSH=1, ID_FLUSH=1.
  2. FC_BR_TAKEN: same outputs with PC_DIN=BR_TGT. Branch overrides HAZ_STALL and IMISS; stay in RUN.
  3. FC_IMISS: PC_LD=1, PC_STALL=1, IF_FLUSH=1; go to MISS; MISS_CNT+1.
  4. FC_HAZ_STALL: PC_LD=1, PC_STALL=1, no flush.
  5. Otherwise: PC_LD=1, PC_STALL=0, PC_DIN=CUR_PC+4 (mod 2^32, 0xFFFFFFFC wraps to 0).
- MISS state:
  - PC_STALL=1, IF_FLUSH=1.
  - TRAP or BR_TAKEN latches a pending target. Trap replaces any pending branch. A later branch does not replace a pending trap. A later trap replaces an earlier trap. ID_FLUSH=1 in the request cycle.
  - Timeout counter increments each MISS cycle. On reaching MISS_TIMEOUT, MISS_ERR=1, sticky until reset. The state stays MISS.
  - On FC_IRDY with pending: PC_STALL=0, PC_DIN=pending target, IF_FLUSH=1; clear pending; go to RUN.
  - On FC_IRDY without pending: PC_STALL=0, PC_DIN=CUR_PC (re-fetch the missed address), IF_FLUSH=1; go to RUN.
  - A redirect arriving in the same cycle as IRDY takes effect directly, with trap>branch>pending priority, and clears pending.
  - The timeout counter clears on exit.
- FC_STALL_CNT increments on each non-reset cycle with PC_STALL=1. FC_MISS_CNT increments per entry to MISS. Both saturate at all-ones.
- FC_HAZ_STALL is ignored in MISS.

Test Plan:
- Reset then 3 idle cycles with CUR_PC tracking -> PC_DIN 0x4, 0x8, 0xC; PC_LD=1, PC_STALL=0; counters 0.
- CUR_PC=0x100, BR_TAKEN=1, BR_TGT=0x200, HAZ_STALL=1 same cycle -> PC_DIN=0x200, PC_STALL=0, both flushes 1, STALL_CNT unchanged.
- CUR_PC=0x40, IMISS for 5 cycles, then IRDY -> PC_STALL=1 for 5 cycles, then PC_DIN=0x40, PC_STALL=0; STALL_CNT=5, MISS_CNT=1.
- In MISS: BR_TGT=0x300, then TRAP_TGT=0x1C0, then BR_TGT=0x500, then IRDY -> PC_DIN=0x1C0, IF_FLUSH=1, state RUN.
- MISS_TIMEOUT=8, miss held 10 cycles -> MISS_ERR rises after the 8th MISS cycle and stays 1 after IRDY until FC_RST.
- FC_RST asserted mid-miss with pending 0x300 -> after release and IRDY pulse, no redirect to 0x300, state RUN, PC_DIN=CUR_PC+4.
